ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
- Sits directly downstream of the PC generator and upstream of the decode stage. Turns each accepted fetch PC into one AXI4-Lite read on the instruction bus, then presents {inst, pc, fault} to decode over valid/ready.
- At most one transaction is outstanding. A redirect (flush) discards any in-flight or held fetch.

Parameters:
- ADDR_W, 32, fetch address and PC width.
- DATA_W, 32, instruction width. Fixed at 32; any other value is illegal.
- NOP_INST, 32'h00000013, instruction substituted on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pc_valid  in  1  PC generator offers a fetch address.
- pc_ready  out  1  address accepted this cycle.
- pc_addr  in  ADDR_W  fetch address.
- flush  in  1  redirect; kill current fetch.
- araddr  out  ADDR_W  AXI AR address.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rdata  in  DATA_W  AXI R data.
- rresp  in  2  AXI R response.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst  out  DATA_W  instruction.
- inst_pc  out  ADDR_W  PC of inst.
- inst_fault  out  1  misaligned or bus-error fetch.

Behaviour:
- States: IDLE, ADDR, DATA, OUT. Reset forces IDLE, drop=0, and zeroes addr_q/inst_q/fault_q. All outputs are 0 in reset and in IDLE, except pc_ready, which is 1 in IDLE.
- IDLE:
  - pc_ready = !flush.
  - On pc_valid && pc_ready: latch addr_q = pc_addr.
  - If pc_addr[1:0] != 0: inst_q = NOP_INST, fault_q = 1, go to OUT. No bus access.
  - Otherwise go to ADDR.
- ADDR:
  - arvalid = 1, araddr = addr_q, held stable until arready (AXI rule: arvalid is never withdrawn).
  - On arready: go to DATA.
  - flush here sets drop = 1; the state is unchanged.
- DATA:
  - rready = 1.
  - On rvalid with drop = 1: clear drop, go to IDLE.
  - On rvalid with drop = 0 and flush = 0:
    - inst_q = (rresp == 0) ? rdata : NOP_INST.
    - fault_q = (rresp != 0).
    - Go to OUT.
  - On rvalid with drop = 0 and flush = 1: discard the data, go to IDLE.
  - flush without rvalid sets drop = 1.
- OUT:
  - inst_valid = !flush; inst = inst_q; inst_pc = addr_q; inst_fault = fault_q.
  - Outputs are stable while inst_ready = 0.
  - On inst_valid && inst_ready: go to IDLE.
  - On flush: go to IDLE. The instruction is never handed over.
- Minimum latency with a zero-wait bus: pc accept cycle 0, AR handshake cycle 1, R beat cycle 2, inst_valid cycle 3.
- Simultaneous events:
  - flush has priority over pc accept.
  - flush together with inst_ready in OUT counts as no transfer.
- drop is checked only in DATA and is always cleared on the R beat.
- Reset mid-transaction returns to IDLE immediately. Bus recovery is outside this block; the interconnect is reset by the same rst.
- Throughput is one fetch per 4 cycles minimum. This is intended for the multi-cycle core.

Decomposition:
- Shared package core_pkg:
  - fetch state enum (IDLE/ADDR/DATA/OUT).
  - NOP_INST constant.
  - AXI response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
- No sub-module needed. The FSM and output registers are a single module.

Test Plan:
- Zero-wait fetch: pc_addr=32'h80000000, memory returns 32'h00100093, inst_ready=1. Expect arvalid at cycle 1, inst_valid at cycle 3 with inst=32'h00100093, inst_pc=32'h80000000, fault=0, then pc_ready=1.
- Backpressure: arready delayed 3 cycles, rvalid delayed 2, inst_ready low 4 cycles. Expect araddr/arvalid stable throughout and inst/inst_pc stable until the handshake. Exactly one transfer occurs.
- Flush during ADDR: flush at cycle 2 of the AR wait, then R returns 32'hdeadbeef. Expect no inst_valid, return to IDLE, and the next fetch of 32'h80000010 delivers the correct data.
- Misaligned: pc_addr=32'h80000002. Expect no arvalid; next cycle inst_valid=1, inst=32'h00000013, fault=1, inst_pc=32'h80000002.
- Bus error: rresp=2'b10 with rdata=32'hffffffff. Expect inst=32'h00000013, inst_fault=1.
- Reset in DATA: assert rst while waiting for R. Next cycle: IDLE, all outputs 0, pc_ready=1. The pending R beat is not consumed (rready=0).

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-side definitions: FSM state encoding, the fault-substitution
// instruction and the AXI read response codes.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one AXI4-Lite read per accepted PC, result
// handed to decode over valid/ready. At most one fetch in flight.
//
// state | meaning
// IDLE  | waiting for a PC; pc_ready unless flushing
// ADDR  | AR channel presented, waiting for arready
// DATA  | waiting for the R beat; drop marks a fetch killed by flush
// OUT   | instruction held for decode until accepted or flushed
module ifu_fetch_ctrl
    import core_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("ifu_fetch_ctrl: DATA_W must be 32");
    end

    fetch_state_e      state, state_n;
    logic              drop, drop_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] inst_q, inst_n;
    logic              fault_q, fault_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            drop    <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_n;
            drop    <= drop_n;
            addr_q  <= addr_n;
            inst_q  <= inst_n;
            fault_q <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        drop_n     = drop;
        addr_n     = addr_q;
        inst_n     = inst_q;
        fault_n    = fault_q;
        pc_ready   = 1'b0;
        araddr     = '0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        inst_fault = 1'b0;

        // Handshake outputs are held low while rst is asserted so nothing is
        // accepted or consumed on the reset edge.
        if (!rst) begin
            unique case (state)
                ST_IDLE: begin
                    pc_ready = !flush;
                    if (pc_valid && !flush) begin
                        addr_n = pc_addr;
                        if (pc_addr[1:0] != 2'b00) begin
                            inst_n  = NOP_INST;
                            fault_n = 1'b1;
                            state_n = ST_OUT;
                        end else begin
                            state_n = ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    arvalid = 1'b1;
                    araddr  = addr_q;
                    if (flush) drop_n = 1'b1;
                    if (arready) state_n = ST_DATA;
                end
                ST_DATA: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        drop_n  = 1'b0;
                        state_n = ST_IDLE;
                        if (!drop && !flush) begin
                            inst_n  = (rresp == RESP_OKAY) ? rdata : NOP_INST;
                            fault_n = (rresp != RESP_OKAY);
                            state_n = ST_OUT;
                        end
                    end else if (flush) begin
                        drop_n = 1'b1;
                    end
                end
                ST_OUT: begin
                    inst_valid = !flush;
                    inst       = inst_q;
                    inst_pc    = addr_q;
                    inst_fault = fault_q;
                    if (flush || inst_ready) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a flag-based fetch model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid, pc_ready;
    logic [31:0] pc_addr;
    logic        flush;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        inst_fault;

    int n_tests = 0;
    int n_fail  = 0;
    int xfers   = 0;
    int ar_hs   = 0;
    int r_hs    = 0;
    int r_hs_in_rst = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_addr(pc_addr), .flush(flush),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    // Model: a fetch is either absent or carries flags for how far it got.
    logic        m_busy, m_ar_done, m_have_inst, m_killed;
    logic [31:0] m_addr, m_inst;
    logic        m_fault;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_ar_done = 0; m_have_inst = 0; m_killed = 0;
            m_addr = 0; m_inst = 0; m_fault = 0;
        end else if (!m_busy) begin
            if (pc_valid && !flush) begin
                m_busy = 1; m_addr = pc_addr; m_ar_done = 0; m_killed = 0;
                if (pc_addr % 4 != 0) begin
                    m_have_inst = 1; m_inst = NOP; m_fault = 1;
                end else begin
                    m_have_inst = 0;
                end
            end
        end else if (m_have_inst) begin
            if (flush || inst_ready) begin
                m_busy = 0; m_have_inst = 0;
            end
        end else if (!m_ar_done) begin
            if (flush) m_killed = 1;
            if (arready) m_ar_done = 1;
        end else begin
            if (rvalid) begin
                if (m_killed || flush) begin
                    m_busy = 0; m_killed = 0;
                end else begin
                    m_have_inst = 1;
                    m_fault = (rresp != 2'b00);
                    m_inst  = m_fault ? NOP : rdata;
                end
            end else if (flush) begin
                m_killed = 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready) xfers++;
        if (!rst && arvalid && arready) ar_hs++;
        if (rvalid && rready) begin
            r_hs++;
            if (rst) r_hs_in_rst++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [31:0] e_pcr, e_arv, e_ara, e_rr, e_iv, e_inst, e_pc, e_f;
            e_pcr  = 32'(!m_busy && !flush);
            e_arv  = 32'(m_busy && !m_have_inst && !m_ar_done);
            e_ara  = (e_arv != 0) ? m_addr : 32'h0;
            e_rr   = 32'(m_busy && !m_have_inst && m_ar_done);
            e_iv   = 32'(m_busy && m_have_inst && !flush);
            e_inst = (m_busy && m_have_inst) ? m_inst : 32'h0;
            e_pc   = (m_busy && m_have_inst) ? m_addr : 32'h0;
            e_f    = 32'(m_busy && m_have_inst && m_fault);
            n_tests++;
            if ({32'(pc_ready), 32'(arvalid), araddr, 32'(rready), 32'(inst_valid),
                 inst, inst_pc, 32'(inst_fault)} !==
                {e_pcr, e_arv, e_ara, e_rr, e_iv, e_inst, e_pc, e_f}) begin
                n_fail++;
                $display("FAIL model t=%0t got pcr=%0d arv=%0d ara=%h rr=%0d iv=%0d inst=%h pc=%h f=%0d want pcr=%0d arv=%0d ara=%h rr=%0d iv=%0d inst=%h pc=%h f=%0d",
                         $time, pc_ready, arvalid, araddr, rready, inst_valid, inst, inst_pc, inst_fault,
                         e_pcr, e_arv, e_ara, e_rr, e_iv, e_inst, e_pc, e_f);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pc_valid = 0; pc_addr = 0; flush = 0; arready = 0;
        rdata = 0; rresp = 0; rvalid = 0; inst_ready = 0;
    endtask

    // Zero-wait fetch of a, returning d; leaves the controller in OUT.
    task automatic fetch_to_out(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        pc_valid = 1; pc_addr = a; arready = 1; tick();
        pc_valid = 0; tick();
        rvalid = 1; rdata = d; rresp = resp; tick();
        rvalid = 0; arready = 0; #1;
    endtask

    int x0, a0;

    initial begin
        quiet();
        rst = 1;
        tick(); tick();
        rst = 0; #1;
        chk("reset_pc_ready", 32'(pc_ready), 1);
        chk("reset_arvalid", 32'(arvalid), 0);
        chk("reset_inst_valid", 32'(inst_valid), 0);

        // Zero-wait fetch: accept c0, AR c1, R c2, inst_valid c3.
        pc_valid = 1; pc_addr = 32'h8000_0000; arready = 1; inst_ready = 1; #1;
        chk("zw_c0_pc_ready", 32'(pc_ready), 1);
        tick(); pc_valid = 0; #1;
        chk("zw_c1_arvalid", 32'(arvalid), 1);
        chk("zw_c1_araddr", araddr, 32'h8000_0000);
        tick(); rvalid = 1; rdata = 32'h0010_0093; #1;
        chk("zw_c2_rready", 32'(rready), 1);
        chk("zw_c2_inst_valid", 32'(inst_valid), 0);
        tick(); rvalid = 0; #1;
        chk("zw_c3_inst_valid", 32'(inst_valid), 1);
        chk("zw_c3_inst", inst, 32'h0010_0093);
        chk("zw_c3_inst_pc", inst_pc, 32'h8000_0000);
        chk("zw_c3_fault", 32'(inst_fault), 0);
        tick(); #1;
        chk("zw_c4_pc_ready", 32'(pc_ready), 1);
        quiet(); tick();

        // Backpressure on every channel.
        x0 = xfers;
        pc_valid = 1; pc_addr = 32'h8000_0004; tick(); pc_valid = 0; pc_addr = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_arvalid_hold", 32'(arvalid), 1);
            chk("bp_araddr_hold", araddr, 32'h8000_0004);
            tick();
        end
        arready = 1; tick(); arready = 0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("bp_rready_wait", 32'(rready), 1); tick();
        end
        rvalid = 1; rdata = 32'h1234_5678; tick(); rvalid = 0; rdata = 32'hffff_ffff;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_inst_hold", inst, 32'h1234_5678);
            chk("bp_pc_hold", inst_pc, 32'h8000_0004);
            tick();
        end
        inst_ready = 1; tick(); inst_ready = 0; #1;
        chk("bp_one_transfer", 32'(xfers - x0), 1);

        // Flush on the second AR-wait cycle; late data must be dropped.
        x0 = xfers;
        pc_valid = 1; pc_addr = 32'h8000_0008; tick(); pc_valid = 0;
        tick(); flush = 1; tick(); flush = 0;
        arready = 1; tick(); arready = 0;
        rvalid = 1; rdata = 32'hdead_beef; tick(); rvalid = 0; #1;
        chk("fl_back_idle", 32'(pc_ready), 1);
        inst_ready = 1;
        fetch_to_out(32'h8000_0010, 32'h00a0_0113, 2'b00);
        chk("fl_next_inst", inst, 32'h00a0_0113);
        chk("fl_next_pc", inst_pc, 32'h8000_0010);
        tick();
        chk("fl_only_next_transfer", 32'(xfers - x0), 1);
        quiet();

        // Misaligned: no bus access, NOP with fault next cycle.
        a0 = ar_hs;
        pc_valid = 1; pc_addr = 32'h8000_0002; arready = 1; tick(); pc_valid = 0; #1;
        chk("mis_arvalid", 32'(arvalid), 0);
        chk("mis_inst_valid", 32'(inst_valid), 1);
        chk("mis_inst", inst, NOP);
        chk("mis_fault", 32'(inst_fault), 1);
        chk("mis_pc", inst_pc, 32'h8000_0002);
        inst_ready = 1; tick(); quiet(); #1;
        chk("mis_no_ar", 32'(ar_hs - a0), 0);

        // Bus error replaced by NOP.
        fetch_to_out(32'h8000_0020, 32'hffff_ffff, 2'b10);
        chk("err_inst", inst, NOP);
        chk("err_fault", 32'(inst_fault), 1);
        inst_ready = 1; tick(); quiet();

        // Flush together with inst_ready in OUT: no transfer.
        x0 = xfers;
        fetch_to_out(32'h8000_0030, 32'h0000_0073, 2'b00);
        flush = 1; inst_ready = 1; #1;
        chk("flout_inst_valid", 32'(inst_valid), 0);
        chk("flout_pc_ready", 32'(pc_ready), 0);
        tick(); flush = 0; inst_ready = 0; #1;
        chk("flout_idle", 32'(pc_ready), 1);
        chk("flout_no_transfer", 32'(xfers - x0), 0);

        // Flush coincident with the R beat discards the data.
        pc_valid = 1; pc_addr = 32'h8000_0040; arready = 1; tick(); pc_valid = 0;
        tick(); arready = 0; rvalid = 1; rdata = 32'h1111_1111; flush = 1; tick();
        quiet(); #1;
        chk("flr_idle", 32'(pc_ready), 1);
        chk("flr_no_inst", 32'(inst_valid), 0);

        // Reset while waiting for R; pending beat is not consumed.
        pc_valid = 1; pc_addr = 32'h8000_0050; arready = 1; tick(); pc_valid = 0;
        tick(); arready = 0; tick();
        rvalid = 1; rdata = 32'h2222_2222; rst = 1; #1;
        chk("rst_rready_low", 32'(rready), 0);
        tick(); rst = 0; #1;
        chk("rst_pc_ready", 32'(pc_ready), 1);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_beat_not_taken", 32'(r_hs_in_rst), 0);
        quiet(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
